// File: rtl/latmon_pkg.sv
// Shared types and helpers for the checkpoint latency monitor.
// Holds the per-channel state encoding, the saturating increment used by the
// latency and run counters, and the min/max reset constants.
package latmon_pkg;

    typedef enum logic {
        LM_IDLE = 1'b0,
        LM_RUN  = 1'b1
    } lm_state_t;

    // Widest counter the helper supports; callers truncate to their width.
    localparam int LM_MAX_W = 64;

    // Minimum starts at all-ones so the first completed run always replaces it.
    localparam logic [LM_MAX_W-1:0] LM_MIN_RST = {LM_MAX_W{1'b1}};
    localparam logic [LM_MAX_W-1:0] LM_MAX_RST = {LM_MAX_W{1'b0}};

    // Increment value, sticking at the all-ones ceiling of a width-bit counter.
    function automatic logic [LM_MAX_W-1:0] sat_inc(input logic [LM_MAX_W-1:0] value,
                                                    input int                  width);
        logic [LM_MAX_W-1:0] ceiling;
        if (width >= LM_MAX_W) begin
            ceiling = {LM_MAX_W{1'b1}};
        end else begin
            ceiling = (LM_MAX_W'(1) << width) - LM_MAX_W'(1);
        end
        if (value >= ceiling) begin
            return ceiling;
        end
        return value + LM_MAX_W'(1);
    endfunction

endpackage

// File: rtl/latmon_channel.sv
// One latency-measurement channel: IDLE/RUN state machine, saturating cycle
// counter and the last/min/max/run-count statistics for that channel.
// Min/max tracking exists only when LATMON_MINMAX_EN is defined; otherwise
// min_lat and max_lat are constant zero.
module latmon_channel
    import latmon_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int RUN_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             start_hit,
    input  logic             end_hit,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [CNT_W-1:0] last,
    output logic [CNT_W-1:0] min_lat,
    output logic [CNT_W-1:0] max_lat,
    output logic [RUN_W-1:0] runs
);

    lm_state_t        state;
    lm_state_t        next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_full;
    logic [RUN_W-1:0] runs_inc;
    logic             take_start;
    logic             take_end;

    assign cnt_inc  = CNT_W'(sat_inc(LM_MAX_W'(cnt), CNT_W));
    assign cnt_full = (cnt_inc == {CNT_W{1'b1}});
    assign runs_inc = RUN_W'(sat_inc(LM_MAX_W'(runs), RUN_W));

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= LM_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: clear and disable abort runs; a start is ignored while running.
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = LM_IDLE;
        end else begin
            case (state)
                LM_IDLE: if (start_hit && enable) next_state = LM_RUN;
                LM_RUN:  if (!enable || end_hit)  next_state = LM_IDLE;
                default: next_state = LM_IDLE;
            endcase
        end
    end

    // Decoded actions for the datapath; clear suppresses a same-cycle end.
    always_comb begin
        busy       = (state == LM_RUN);
        take_start = (state == LM_IDLE) && start_hit && enable && !clear;
        take_end   = (state == LM_RUN) && end_hit && enable && !clear;
    end

    // Counter, last latency, run count, overflow flag and completion pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt  <= '0;
            last <= '0;
            runs <= '0;
            ovf  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= take_end;
            if (clear) begin
                cnt  <= '0;
                last <= '0;
                runs <= '0;
                ovf  <= 1'b0;
            end else if (take_start) begin
                cnt <= '0;
            end else if (take_end) begin
                last <= cnt_inc;
                runs <= runs_inc;
                if (cnt_full) ovf <= 1'b1;
            end else if (busy && enable) begin
                cnt <= cnt_inc;
                if (cnt_full) ovf <= 1'b1;
            end
        end
    end

`ifdef LATMON_MINMAX_EN
    logic [CNT_W-1:0] min_q;
    logic [CNT_W-1:0] max_q;

    // Extremes of the completed latencies since the last reset or clear.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            min_q <= CNT_W'(LM_MIN_RST);
            max_q <= CNT_W'(LM_MAX_RST);
        end else if (take_end) begin
            if (cnt_inc < min_q) min_q <= cnt_inc;
            if (cnt_inc > max_q) max_q <= cnt_inc;
        end
    end

    assign min_lat = min_q;
    assign max_lat = max_q;
`else
    assign min_lat = '0;
    assign max_lat = '0;
`endif

endmodule

// File: rtl/checkpoint_latency_monitor.sv
// Multi-channel latency monitor on the firmware checkpoint bus.
// Registers the asynchronous checkbits twice, decodes per-channel start (edge)
// and end (level) hits, runs one latmon_channel per channel and muxes the
// selected channel's statistics onto the readout port.
// Optional build macro: LATMON_MINMAX_EN enables per-channel min/max tracking.
module checkpoint_latency_monitor
    import latmon_pkg::*;
#(
    parameter int MARK_W = 16,
    parameter int CNT_W  = 32,
    parameter int RUN_W  = 16,
    parameter int N_CH   = 4,
    parameter int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     en_i,
    input  logic                     clear_i,
    input  logic [MARK_W-1:0]        checkbits_i,
    input  logic [N_CH*MARK_W-1:0]   start_mark_i,
    input  logic [N_CH*MARK_W-1:0]   end_mark_i,
    output logic [N_CH-1:0]          busy_o,
    output logic [N_CH-1:0]          done_o,
    output logic [N_CH-1:0]          ovf_o,
    input  logic [SEL_W-1:0]         rd_sel_i,
    output logic [CNT_W-1:0]         rd_last_o,
    output logic [CNT_W-1:0]         rd_min_o,
    output logic [CNT_W-1:0]         rd_max_o,
    output logic [RUN_W-1:0]         rd_runs_o
);

    logic [MARK_W-1:0] cb_q;
    logic [MARK_W-1:0] cb_qq;
    logic [N_CH-1:0]   start_hit;
    logic [N_CH-1:0]   end_hit;

    logic [CNT_W-1:0]  ch_last [N_CH];
    logic [CNT_W-1:0]  ch_min  [N_CH];
    logic [CNT_W-1:0]  ch_max  [N_CH];
    logic [RUN_W-1:0]  ch_runs [N_CH];

    // Two-stage capture of the checkpoint bus; the second stage gives edge detection.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cb_q  <= '0;
            cb_qq <= '0;
        end else begin
            cb_q  <= checkbits_i;
            cb_qq <= cb_q;
        end
    end

    // Start fires only when the marker newly appears; end fires on level.
    always_comb begin
        start_hit = '0;
        end_hit   = '0;
        for (int c = 0; c < N_CH; c++) begin
            start_hit[c] = (cb_q  == start_mark_i[c*MARK_W +: MARK_W]) &&
                           (cb_qq != start_mark_i[c*MARK_W +: MARK_W]);
            end_hit[c]   = (cb_q  == end_mark_i[c*MARK_W +: MARK_W]);
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : gen_ch
        latmon_channel #(
            .CNT_W(CNT_W),
            .RUN_W(RUN_W)
        ) u_channel (
            .clock    (wb_clk_i),
            .reset    (wb_rst_i),
            .enable   (en_i),
            .clear    (clear_i),
            .start_hit(start_hit[c]),
            .end_hit  (end_hit[c]),
            .busy     (busy_o[c]),
            .done     (done_o[c]),
            .ovf      (ovf_o[c]),
            .last     (ch_last[c]),
            .min_lat  (ch_min[c]),
            .max_lat  (ch_max[c]),
            .runs     (ch_runs[c])
        );
    end

    // Zero-latency readout mux; selects beyond the last channel read zero.
    always_comb begin
        rd_last_o = '0;
        rd_min_o  = '0;
        rd_max_o  = '0;
        rd_runs_o = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (rd_sel_i == SEL_W'(c)) begin
                rd_last_o = ch_last[c];
                rd_min_o  = ch_min[c];
                rd_max_o  = ch_max[c];
                rd_runs_o = ch_runs[c];
            end
        end
    end

endmodule

// File: tb/tb_checkpoint_latency_monitor.sv
// Self-checking bench for checkpoint_latency_monitor (3 channels, 8-bit counters
// so saturation is reachable). Expected statistics come from a per-channel model
// that turns each firmware interval into last/min/max/runs/ovf arithmetically.
// Works with or without LATMON_MINMAX_EN.
module tb_checkpoint_latency_monitor;

    localparam int MARK_W = 16;
    localparam int CNT_W  = 8;
    localparam int RUN_W  = 16;
    localparam int N_CH   = 3;
    localparam int SEL_W  = 2;
    localparam int SAT    = (1 << CNT_W) - 1;
`ifdef LATMON_MINMAX_EN
    localparam bit MINMAX = 1'b1;
`else
    localparam bit MINMAX = 1'b0;
`endif

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic                   en = 1'b1;
    logic                   clear = 1'b0;
    logic [MARK_W-1:0]      checkbits = '0;
    logic [N_CH*MARK_W-1:0] start_marks = {16'h0033, 16'h0011, 16'h00A5};
    logic [N_CH*MARK_W-1:0] end_marks   = {16'h0022, 16'h0022, 16'h005A};
    logic [N_CH-1:0]        busy, done, ovf;
    logic [SEL_W-1:0]       rd_sel = '0;
    logic [CNT_W-1:0]       rd_last, rd_min, rd_max;
    logic [RUN_W-1:0]       rd_runs;

    logic [MARK_W-1:0] start_of [N_CH] = '{16'h00A5, 16'h0011, 16'h0033};
    logic [MARK_W-1:0] end_of   [N_CH] = '{16'h005A, 16'h0022, 16'h0022};

    int checks = 0;
    int errors = 0;
    int done_cnt [N_CH] = '{0, 0, 0};

    // Reference model state per channel.
    int m_last [N_CH];
    int m_runs [N_CH];
    int m_min  [N_CH];
    int m_max  [N_CH];
    bit m_ovf  [N_CH];

    checkpoint_latency_monitor #(
        .MARK_W(MARK_W), .CNT_W(CNT_W), .RUN_W(RUN_W), .N_CH(N_CH), .SEL_W(SEL_W)
    ) dut (
        .wb_clk_i    (clock),
        .wb_rst_i    (reset),
        .en_i        (en),
        .clear_i     (clear),
        .checkbits_i (checkbits),
        .start_mark_i(start_marks),
        .end_mark_i  (end_marks),
        .busy_o      (busy),
        .done_o      (done),
        .ovf_o       (ovf),
        .rd_sel_i    (rd_sel),
        .rd_last_o   (rd_last),
        .rd_min_o    (rd_min),
        .rd_max_o    (rd_max),
        .rd_runs_o   (rd_runs)
    );

    always #5 clock = ~clock;

    // Count completion pulses per channel, sampled mid-cycle.
    always @(negedge clock) begin
        for (int c = 0; c < N_CH; c++) begin
            if (done[c] === 1'b1) done_cnt[c]++;
        end
    end

    // Bounded run time in case the DUT wedges the stimulus flow.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "[TB] watchdog");
    end

    // Advance n active edges and land 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic read_ch(input int c, output logic [CNT_W-1:0] last, output logic [CNT_W-1:0] mn,
                           output logic [CNT_W-1:0] mx, output logic [RUN_W-1:0] runs);
        rd_sel = SEL_W'(c);
        #1;
        last = rd_last;
        mn   = rd_min;
        mx   = rd_max;
        runs = rd_runs;
    endtask

    // Firmware puts the start marker up, then the end marker L cycles later.
    task automatic do_run(input int c, input int lat);
        checkbits = start_of[c];
        step(lat);
        checkbits = end_of[c];
        step(3);
        checkbits = '0;
        step(1);
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    function automatic void model_clear();
        for (int c = 0; c < N_CH; c++) begin
            m_last[c] = 0; m_runs[c] = 0; m_min[c] = SAT; m_max[c] = 0; m_ovf[c] = 1'b0;
        end
    endfunction

    function automatic void model_run(input int c, input int lat);
        int v;
        v = (lat > SAT) ? SAT : lat;
        m_last[c] = v;
        m_runs[c]++;
        if (v < m_min[c]) m_min[c] = v;
        if (v > m_max[c]) m_max[c] = v;
        if (lat >= SAT) m_ovf[c] = 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] exp_mm(input int v);
        return MINMAX ? CNT_W'(v) : '0;
    endfunction

    task automatic test_reset();
        logic [CNT_W-1:0] l, mn, mx;
        logic [RUN_W-1:0] r;
        reset = 1'b1;
        step(2);
        model_clear();
        checks++; if (busy !== '0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== '0) begin errors++; $display("[TB] FAIL reset_done got %b exp 0", done); end
        checks++; if (ovf !== '0)  begin errors++; $display("[TB] FAIL reset_ovf got %b exp 0", ovf); end
        for (int c = 0; c <= N_CH; c++) begin
            read_ch(c, l, mn, mx, r);
            checks++; if (l !== '0) begin errors++; $display("[TB] FAIL reset_last ch%0d got %0h exp 0", c, l); end
            checks++; if (r !== '0) begin errors++; $display("[TB] FAIL reset_runs ch%0d got %0h exp 0", c, r); end
            checks++; if (mn !== ((c < N_CH) ? exp_mm(SAT) : '0))
                begin errors++; $display("[TB] FAIL reset_min ch%0d got %0h", c, mn); end
            checks++; if (mx !== '0) begin errors++; $display("[TB] FAIL reset_max ch%0d got %0h exp 0", c, mx); end
        end
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_latency();
        logic [CNT_W-1:0] l, mn, mx;
        logic [RUN_W-1:0] r;
        int d0;
        d0 = done_cnt[0];
        checkbits = 16'h00A5;
        step(1);
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("[TB] FAIL busy_early got %b exp 0", busy[0]); end
        step(1);
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("[TB] FAIL busy_rise got %b exp 1", busy[0]); end
        step(98);
        checkbits = 16'h005A;
        step(1);
        checks++; if (done[0] !== 1'b0) begin errors++; $display("[TB] FAIL done_early got %b exp 0", done[0]); end
        step(1);
        checks++; if (done[0] !== 1'b1) begin errors++; $display("[TB] FAIL done_pulse got %b exp 1", done[0]); end
        step(1);
        checkbits = '0;
        step(1);
        model_run(0, 100);
        checks++; if (done_cnt[0] - d0 !== 1) begin errors++; $display("[TB] FAIL latency_done_count got %0d exp 1", done_cnt[0] - d0); end
        read_ch(0, l, mn, mx, r);
        checks++; if (l !== CNT_W'(m_last[0])) begin errors++; $display("[TB] FAIL latency_last got %0d exp %0d", l, m_last[0]); end
        checks++; if (r !== RUN_W'(m_runs[0])) begin errors++; $display("[TB] FAIL latency_runs got %0d exp %0d", r, m_runs[0]); end
        checks++; if (mn !== exp_mm(m_min[0])) begin errors++; $display("[TB] FAIL latency_min got %0d exp %0d", mn, exp_mm(m_min[0])); end
    endtask

    task automatic test_held_start();
        logic [CNT_W-1:0] l, mn, mx;
        logic [RUN_W-1:0] r;
        int d0;
        d0 = done_cnt[0];
        checkbits = 16'h00A5;
        step(50);
        checkbits = '0;
        step(70);
        checkbits = 16'h005A;
        step(3);
        checkbits = '0;
        step(1);
        model_run(0, 120);
        checks++; if (done_cnt[0] - d0 !== 1) begin errors++; $display("[TB] FAIL held_done_count got %0d exp 1", done_cnt[0] - d0); end
        read_ch(0, l, mn, mx, r);
        checks++; if (l !== CNT_W'(m_last[0])) begin errors++; $display("[TB] FAIL held_last got %0d exp %0d", l, m_last[0]); end
        clear_pulse();
        model_clear();
        do_run(0, 30);  model_run(0, 30);
        do_run(0, 80);  model_run(0, 80);
        do_run(0, 55);  model_run(0, 55);
        read_ch(0, l, mn, mx, r);
        checks++; if (l !== CNT_W'(m_last[0])) begin errors++; $display("[TB] FAIL mm_last got %0d exp %0d", l, m_last[0]); end
        checks++; if (r !== RUN_W'(m_runs[0])) begin errors++; $display("[TB] FAIL mm_runs got %0d exp %0d", r, m_runs[0]); end
        checks++; if (mn !== exp_mm(m_min[0])) begin errors++; $display("[TB] FAIL mm_min got %0d exp %0d", mn, exp_mm(m_min[0])); end
        checks++; if (mx !== exp_mm(m_max[0])) begin errors++; $display("[TB] FAIL mm_max got %0d exp %0d", mx, exp_mm(m_max[0])); end
    endtask

    task automatic test_overlap();
        logic [CNT_W-1:0] l, mn, mx;
        logic [RUN_W-1:0] r;
        checkbits = 16'h0011;
        step(10);
        checkbits = 16'h0033;
        step(30);
        checkbits = 16'h0022;
        step(2);
        checks++; if (done !== 3'b110) begin errors++; $display("[TB] FAIL overlap_done got %b exp 110", done); end
        step(1);
        checkbits = '0;
        step(1);
        model_run(1, 40);
        model_run(2, 30);
        for (int c = 1; c < N_CH; c++) begin
            read_ch(c, l, mn, mx, r);
            checks++; if (l !== CNT_W'(m_last[c])) begin errors++; $display("[TB] FAIL overlap_last ch%0d got %0d exp %0d", c, l, m_last[c]); end
            checks++; if (r !== RUN_W'(m_runs[c])) begin errors++; $display("[TB] FAIL overlap_runs ch%0d got %0d exp %0d", c, r, m_runs[c]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [CNT_W-1:0] l, mn, mx;
        logic [RUN_W-1:0] r;
        int d0;
        d0 = done_cnt[0];
        checkbits = 16'h00A5;
        step(25);
        checkbits = 16'h005A;
        step(1);
        checkbits = 16'h00A5;
        step(35);
        checkbits = 16'h005A;
        step(3);
        checkbits = '0;
        step(1);
        model_run(0, 25);
        model_run(0, 35);
        checks++; if (done_cnt[0] - d0 !== 2) begin errors++; $display("[TB] FAIL b2b_done_count got %0d exp 2", done_cnt[0] - d0); end
        read_ch(0, l, mn, mx, r);
        checks++; if (l !== CNT_W'(m_last[0])) begin errors++; $display("[TB] FAIL b2b_last got %0d exp %0d", l, m_last[0]); end
        checks++; if (r !== RUN_W'(m_runs[0])) begin errors++; $display("[TB] FAIL b2b_runs got %0d exp %0d", r, m_runs[0]); end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] l, mn, mx;
        logic [RUN_W-1:0] r;
        do_run(0, 300);
        model_run(0, 300);
        read_ch(0, l, mn, mx, r);
        checks++; if (l !== CNT_W'(m_last[0])) begin errors++; $display("[TB] FAIL sat_last got %0h exp %0h", l, m_last[0]); end
        checks++; if (ovf[0] !== m_ovf[0]) begin errors++; $display("[TB] FAIL sat_ovf got %b exp %b", ovf[0], m_ovf[0]); end
        checks++; if (mx !== exp_mm(m_max[0])) begin errors++; $display("[TB] FAIL sat_max got %0h exp %0h", mx, exp_mm(m_max[0])); end
        do_run(0, 20);
        model_run(0, 20);
        read_ch(0, l, mn, mx, r);
        checks++; if (l !== CNT_W'(m_last[0])) begin errors++; $display("[TB] FAIL sat_next_last got %0d exp %0d", l, m_last[0]); end
        checks++; if (ovf[0] !== m_ovf[0]) begin errors++; $display("[TB] FAIL sat_sticky got %b exp %b", ovf[0], m_ovf[0]); end
        clear_pulse();
        model_clear();
        read_ch(0, l, mn, mx, r);
        checks++; if (ovf !== '0) begin errors++; $display("[TB] FAIL sat_clear_ovf got %b exp 0", ovf); end
        checks++; if (r !== '0) begin errors++; $display("[TB] FAIL sat_clear_runs got %0d exp 0", r); end
    endtask

    task automatic test_abort();
        logic [CNT_W-1:0] l, mn, mx;
        logic [RUN_W-1:0] r;
        int d0;
        do_run(0, 15);
        model_run(0, 15);
        d0 = done_cnt[0];
        checkbits = 16'h00A5;
        step(20);
        checks++; if (busy[0] !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy_pre got %b exp 1", busy[0]); end
        en = 1'b0;
        step(1);
        en = 1'b1;
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b exp 0", busy[0]); end
        checkbits = 16'h005A;
        step(3);
        checkbits = '0;
        step(1);
        checks++; if (done_cnt[0] !== d0) begin errors++; $display("[TB] FAIL abort_done got %0d exp %0d", done_cnt[0], d0); end
        read_ch(0, l, mn, mx, r);
        checks++; if (r !== RUN_W'(m_runs[0])) begin errors++; $display("[TB] FAIL abort_runs got %0d exp %0d", r, m_runs[0]); end
        checks++; if (l !== CNT_W'(m_last[0])) begin errors++; $display("[TB] FAIL abort_last got %0d exp %0d", l, m_last[0]); end
        // clear lands on the same edge that would record the end
        checkbits = 16'h00A5;
        step(30);
        checkbits = 16'h005A;
        step(1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        model_clear();
        checks++; if (done[0] !== 1'b0) begin errors++; $display("[TB] FAIL collide_done got %b exp 0", done[0]); end
        step(2);
        checkbits = '0;
        read_ch(0, l, mn, mx, r);
        checks++; if (l !== '0) begin errors++; $display("[TB] FAIL collide_last got %0d exp 0", l); end
        checks++; if (mn !== exp_mm(m_min[0])) begin errors++; $display("[TB] FAIL collide_min got %0h exp %0h", mn, exp_mm(m_min[0])); end
        checks++; if (busy !== '0) begin errors++; $display("[TB] FAIL collide_busy got %b exp 0", busy); end
        step(1);
    endtask

    task automatic test_reset_mid_run();
        logic [CNT_W-1:0] l, mn, mx;
        logic [RUN_W-1:0] r;
        int d0;
        do_run(0, 12);
        checkbits = 16'h00A5;
        step(5);
        checkbits = 16'h0001;
        step(35);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        model_clear();
        checks++; if (busy !== '0) begin errors++; $display("[TB] FAIL rst_run_busy got %b exp 0", busy); end
        checks++; if (ovf !== '0)  begin errors++; $display("[TB] FAIL rst_run_ovf got %b exp 0", ovf); end
        read_ch(0, l, mn, mx, r);
        checks++; if (l !== '0) begin errors++; $display("[TB] FAIL rst_run_last got %0d exp 0", l); end
        checks++; if (mn !== exp_mm(m_min[0])) begin errors++; $display("[TB] FAIL rst_run_min got %0h exp %0h", mn, exp_mm(m_min[0])); end
        d0 = done_cnt[0];
        checkbits = 16'h005A;
        step(3);
        checkbits = '0;
        step(1);
        read_ch(0, l, mn, mx, r);
        checks++; if (done_cnt[0] !== d0) begin errors++; $display("[TB] FAIL rst_run_done got %0d exp %0d", done_cnt[0], d0); end
        checks++; if (r !== '0) begin errors++; $display("[TB] FAIL rst_run_runs got %0d exp 0", r); end
    endtask

    task automatic test_random();
        logic [CNT_W-1:0] l, mn, mx;
        logic [RUN_W-1:0] r;
        logic [N_CH-1:0]  exp_ovf;
        int c, lat, rs, d0;
        for (int it = 0; it < 16; it++) begin
            c   = $urandom_range(0, N_CH - 1);
            lat = ($urandom_range(0, 5) == 0) ? $urandom_range(250, 300) : $urandom_range(1, 120);
            d0  = done_cnt[c];
            do_run(c, lat);
            model_run(c, lat);
            checks++; if (done_cnt[c] - d0 !== 1) begin errors++; $display("[TB] FAIL rand_done ch%0d lat %0d got %0d exp 1", c, lat, done_cnt[c] - d0); end
            for (int k = 0; k < N_CH; k++) exp_ovf[k] = m_ovf[k];
            checks++; if (ovf !== exp_ovf) begin errors++; $display("[TB] FAIL rand_ovf got %b exp %b", ovf, exp_ovf); end
            rs = (it % 4 == 3) ? $urandom_range(0, N_CH) : c;
            read_ch(rs, l, mn, mx, r);
            if (rs == N_CH) begin
                checks++; if ({l, mn, mx, r} !== '0) begin errors++; $display("[TB] FAIL rand_oor got %0h %0h %0h %0h exp 0", l, mn, mx, r); end
            end else begin
                checks++; if (l !== CNT_W'(m_last[rs])) begin errors++; $display("[TB] FAIL rand_last ch%0d got %0d exp %0d", rs, l, m_last[rs]); end
                checks++; if (r !== RUN_W'(m_runs[rs])) begin errors++; $display("[TB] FAIL rand_runs ch%0d got %0d exp %0d", rs, r, m_runs[rs]); end
                checks++; if (mn !== exp_mm(m_min[rs])) begin errors++; $display("[TB] FAIL rand_min ch%0d got %0d exp %0d", rs, mn, exp_mm(m_min[rs])); end
                checks++; if (mx !== exp_mm(m_max[rs])) begin errors++; $display("[TB] FAIL rand_max ch%0d got %0d exp %0d", rs, mx, exp_mm(m_max[rs])); end
            end
        end
    endtask

    initial begin
        $display("[TB] checkpoint_latency_monitor bench, min/max build %0d", MINMAX);
        test_reset();
        test_latency();
        test_held_start();
        test_overlap();
        test_back_to_back();
        test_saturation();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
